// File: rtl/vga_pkg.sv
// Shared definitions for the VGA receive-side timing decoder: default
// 640x480@60 timing, the lock state machine encoding and the edge record
// produced by each input synchroniser.
package vga_pkg;

    localparam int H_TOTAL_DEF     = 800;
    localparam int V_TOTAL_DEF     = 525;
    localparam int H_ACTIVE_DEF    = 640;
    localparam int V_ACTIVE_DEF    = 480;
    localparam int CAP_W_DEF       = 256;
    localparam int CAP_H_DEF       = 256;
    localparam int LOCK_FRAMES_DEF = 2;

    typedef enum logic [1:0] {
        SEEK_VS,
        SEEK_HS,
        TRACK,
        LOCKED
    } sync_state_t;

    // Registered level of an input plus its rise/fall pulses.
    typedef struct packed {
        logic level;
        logic rise;
        logic fall;
    } edge_t;

    // Counters stick at all-ones instead of wrapping, so a runaway line or
    // frame can never alias back onto a legal count.
    function automatic logic [9:0] sat_inc(input logic [9:0] v);
        return (v == 10'h3FF) ? v : v + 10'd1;
    endfunction

endpackage

// File: rtl/vga_edge_detect.sv
// Input register for one timing signal plus rise/fall detection on the
// registered copy. The pulses are combinational from two flops, so they line
// up with the registered level seen by the decoder.
module vga_edge_detect
    import vga_pkg::*;
(
    input  logic  clk,
    input  logic  reset,
    input  logic  din,
    output edge_t ed
);

    logic sync_q;
    logic prev_q;

    // Capture the pin, then keep one older copy to compare against.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= din;
            prev_q <= sync_q;
        end
    end

    assign ed = '{level: sync_q, rise: sync_q & ~prev_q, fall: ~sync_q & prev_q};

endmodule

// File: rtl/vga_sync_decoder.sv
// Receive side of the VGA timing interface: recovers pixel position from
// hsync/vsync/blank, verifies line and frame timing, locks after clean frames
// and, once locked, writes the top-left capture window into a RAM using
// row-major y*CAP_W+x addressing.
module vga_sync_decoder
    import vga_pkg::*;
#(
    parameter int H_TOTAL     = H_TOTAL_DEF,
    parameter int V_TOTAL     = V_TOTAL_DEF,
    parameter int H_ACTIVE    = H_ACTIVE_DEF,
    parameter int V_ACTIVE    = V_ACTIVE_DEF,
    parameter int CAP_W       = CAP_W_DEF,
    parameter int CAP_H       = CAP_H_DEF,
    parameter int LOCK_FRAMES = LOCK_FRAMES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        hsync,
    input  logic        vsync,
    input  logic        blank,
    input  logic [7:0]  pix_in,
    output logic [9:0]  px_x,
    output logic [9:0]  px_y,
    output logic        px_valid,
    output logic        frame_start,
    output logic        locked,
    output logic        line_err,
    output logic        frame_err,
    output logic        cap_we,
    output logic [15:0] cap_addr,
    output logic [7:0]  cap_data
);

    edge_t       hs_e;
    edge_t       vs_e;
    edge_t       bl_e;
    logic [7:0]  pix_q;
    logic [9:0]  hcnt;
    logic [9:0]  vcnt;
    logic [7:0]  good_cnt;
    sync_state_t state;

    logic [9:0]  hcnt_next;
    logic [9:0]  vcnt_next;
    logic [9:0]  x_next;
    logic [9:0]  y_next;
    logic        tracking;
    logic        line_bad;
    logic        frame_bad;
    logic        cap_ok;
    logic [15:0] addr_next;
    logic        unused_lvl;

    vga_edge_detect u_hs (.clk(clk), .reset(reset), .din(hsync), .ed(hs_e));
    vga_edge_detect u_vs (.clk(clk), .reset(reset), .din(vsync), .ed(vs_e));
    vga_edge_detect u_bl (.clk(clk), .reset(reset), .din(blank), .ed(bl_e));

    // Only the edges of the sync signals matter; their levels are dropped.
    assign unused_lvl = hs_e.level ^ vs_e.level;

    // Next counter values and timing checks. A vsync edge coinciding with an
    // hsync edge is handled as "new frame first, then line 0 starts", which is
    // why the line count restarts at 1 in that case. Active run length is the
    // last column plus one, so it is checked as x == H_ACTIVE-1 on blank fall.
    always_comb begin
        hcnt_next = hs_e.fall ? 10'd0 : sat_inc(hcnt);
        x_next    = bl_e.rise ? 10'd0 : (bl_e.level ? sat_inc(px_x) : px_x);
        y_next    = vs_e.fall ? 10'd0 : (bl_e.fall ? sat_inc(px_y) : px_y);

        if (vs_e.fall)
            vcnt_next = hs_e.fall ? 10'd1 : 10'd0;
        else if (hs_e.fall)
            vcnt_next = sat_inc(vcnt);
        else
            vcnt_next = vcnt;

        tracking  = (state == TRACK) || (state == LOCKED);
        line_bad  = tracking &&
                    ((hs_e.fall && (hcnt != 10'(H_TOTAL - 1))) ||
                     (bl_e.fall && (px_x != 10'(H_ACTIVE - 1))));
        frame_bad = (state != SEEK_VS) && vs_e.fall &&
                    ((vcnt != 10'(V_TOTAL)) || (px_y != 10'(V_ACTIVE)));

        cap_ok    = (state == LOCKED) && bl_e.level &&
                    (32'(x_next) < 32'(CAP_W)) && (32'(y_next) < 32'(CAP_H)) &&
                    !line_bad && !frame_bad;
        addr_next = 16'(32'(y_next) * 32'(CAP_W) + 32'(x_next));
    end

    // Counters, registered outputs and the lock state machine. Any error pulse
    // throws the decoder back to searching for vsync; locked follows the state
    // one cycle later, while capture gating uses the state directly.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pix_q       <= 8'd0;
            hcnt        <= 10'd0;
            vcnt        <= 10'd0;
            good_cnt    <= 8'd0;
            state       <= SEEK_VS;
            px_x        <= 10'd0;
            px_y        <= 10'd0;
            px_valid    <= 1'b0;
            frame_start <= 1'b0;
            locked      <= 1'b0;
            line_err    <= 1'b0;
            frame_err   <= 1'b0;
            cap_we      <= 1'b0;
            cap_addr    <= 16'd0;
            cap_data    <= 8'd0;
        end else begin
            pix_q       <= pix_in;
            hcnt        <= hcnt_next;
            vcnt        <= vcnt_next;
            px_x        <= x_next;
            px_y        <= y_next;
            px_valid    <= bl_e.level;
            frame_start <= vs_e.fall;
            locked      <= (state == LOCKED);
            line_err    <= line_bad;
            frame_err   <= frame_bad;
            cap_we      <= cap_ok;
            cap_addr    <= addr_next;
            cap_data    <= pix_q;

            if (line_bad || frame_bad) begin
                state    <= SEEK_VS;
                good_cnt <= 8'd0;
            end else begin
                case (state)
                    SEEK_VS: begin
                        good_cnt <= 8'd0;
                        if (vs_e.fall)
                            state <= hs_e.fall ? TRACK : SEEK_HS;
                    end
                    SEEK_HS: begin
                        if (hs_e.fall)
                            state <= TRACK;
                    end
                    TRACK: begin
                        if (vs_e.fall) begin
                            if (good_cnt == 8'(LOCK_FRAMES - 1))
                                state <= LOCKED;
                            else
                                good_cnt <= good_cnt + 8'd1;
                        end
                    end
                    default: begin
                        state <= LOCKED;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed bench for vga_sync_decoder using a scaled-down timing
// (32 clocks x 16 lines, 20x10 active, 16x8 capture window) so that many
// complete frames fit in a short run.
module tb_vga_sync_decoder;

    localparam int HT       = 32;
    localparam int HA       = 20;
    localparam int HS_START = 24;
    localparam int HS_LEN   = 4;
    localparam int VT       = 16;
    localparam int VA       = 10;
    localparam int VS_START = 12;
    localparam int VS_LEN   = 2;
    localparam int CW       = 16;
    localparam int CH       = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        hsync = 1'b1;
    logic        vsync = 1'b1;
    logic        blank = 1'b0;
    logic [7:0]  pix_in = 8'd0;
    logic [9:0]  px_x;
    logic [9:0]  px_y;
    logic        px_valid;
    logic        frame_start;
    logic        locked;
    logic        line_err;
    logic        frame_err;
    logic        cap_we;
    logic [15:0] cap_addr;
    logic [7:0]  cap_data;

    int checks = 0;
    int passed = 0;

    int cyc = 0;
    int fs_cnt = 0;
    int le_cnt = 0;
    int fe_cnt = 0;
    int le_cyc = 0;
    int lock_fall_cyc = 0;
    int cur_frame = 0;
    int wr_cnt [0:19];
    logic        locked_d = 1'b0;
    logic        rec_we_a = 1'b0;
    logic [15:0] rec_addr_a = 16'd0;
    logic [7:0]  rec_data_a = 8'd0;
    logic        rec_we_b = 1'b1;
    logic [15:0] rec_addr_c = 16'd0;
    logic [7:0]  rec_data_c = 8'd0;

    vga_sync_decoder #(
        .H_TOTAL(HT), .V_TOTAL(VT), .H_ACTIVE(HA), .V_ACTIVE(VA),
        .CAP_W(CW), .CAP_H(CH), .LOCK_FRAMES(2)
    ) dut (
        .clk(clk), .reset(reset), .hsync(hsync), .vsync(vsync), .blank(blank),
        .pix_in(pix_in), .px_x(px_x), .px_y(px_y), .px_valid(px_valid),
        .frame_start(frame_start), .locked(locked), .line_err(line_err),
        .frame_err(frame_err), .cap_we(cap_we), .cap_addr(cap_addr), .cap_data(cap_data)
    );

    always #5 clk = ~clk;

    // Observe outputs on the falling edge: pulse counters and a few captured
    // pixel records used by the directed checks.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (frame_start) fs_cnt = fs_cnt + 1;
        if (line_err) begin
            le_cnt = le_cnt + 1;
            le_cyc = cyc;
        end
        if (frame_err) fe_cnt = fe_cnt + 1;
        if (locked_d && !locked) lock_fall_cyc = cyc;
        locked_d = locked;
        if (cap_we) wr_cnt[cur_frame] = wr_cnt[cur_frame] + 1;
        if (cur_frame == 3 && px_valid) begin
            if (px_x == 10'd15 && px_y == 10'd7) begin
                rec_we_a   = cap_we;
                rec_addr_a = cap_addr;
                rec_data_a = cap_data;
            end
            if (px_x == 10'd16 && px_y == 10'd7) rec_we_b = cap_we;
            if (px_x == 10'd3 && px_y == 10'd2) begin
                rec_addr_c = cap_addr;
                rec_data_c = cap_data;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        assert (got === exp) passed = passed + 1;
        else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Drive one frame of vga_driver-style timing. vlen/short_line shorten the
    // frame or one line, vs_off moves the vsync edge onto the hsync edge, and
    // rst_line/rst_h pulse reset in the middle of a line.
    task automatic applyStimulus(input int frame, input int vlen, input int short_line,
                                 input int vs_off, input int rst_line, input int rst_h);
        cur_frame = frame;
        for (int line = 0; line < vlen; line++) begin
            int hlen;
            hlen = (line == short_line) ? HT - 1 : HT;
            for (int h = 0; h < hlen; h++) begin
                int pos;
                pos = line * HT + h;
                @(posedge clk);
                #1;
                blank  = (h < HA) && (line < VA);
                hsync  = !((h >= HS_START) && (h < HS_START + HS_LEN));
                vsync  = !((pos >= VS_START * HT + vs_off) &&
                           (pos < (VS_START + VS_LEN) * HT + vs_off));
                pix_in = (h == 15 && line == 7) ? 8'hA5 : 8'(h + line * 20);
                if (line == rst_line && h == rst_h) begin
                    checkOutput("pre_rst_px_x", 32'(px_x), 32'd10);
                    checkOutput("pre_rst_locked", 32'(locked), 32'd1);
                    checkOutput("pre_rst_cap", 32'({cap_we, cap_addr, cap_data}), 32'h1_002A_32);
                    reset = 1'b0;
                    #1;
                    checkOutput("rst_async_ctl", 32'({px_x, px_y, px_valid, frame_start, locked,
                                                      line_err, frame_err, cap_we}), 32'd0);
                    checkOutput("rst_async_cap", 32'({cap_addr, cap_data}), 32'd0);
                end
                if (line == rst_line && h == rst_h + 3) reset = 1'b1;
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 20; i++) wr_cnt[i] = 0;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_ctl", 32'({px_x, px_y, px_valid, frame_start, locked,
                                      line_err, frame_err, cap_we}), 32'd0);
        checkOutput("reset_cap", 32'({cap_addr, cap_data}), 32'd0);
        reset = 1'b1;

        // Clean loopback: lock after the second full frame.
        applyStimulus(0, VT, -1, 0, -1, -1);
        applyStimulus(1, VT, -1, 0, -1, -1);
        checkOutput("lock_early", 32'(locked), 32'd0);
        applyStimulus(2, VT, -1, 0, -1, -1);
        checkOutput("lock_after_f2", 32'(locked), 32'd1);
        checkOutput("fs_count_3", 32'(fs_cnt), 32'd3);
        checkOutput("clean_errs", 32'(le_cnt + fe_cnt), 32'd0);

        // Capture window contents and edge.
        applyStimulus(3, VT, -1, 0, -1, -1);
        checkOutput("cap_writes_f3", 32'(wr_cnt[3]), 32'd128);
        checkOutput("cap_we_15_7", 32'(rec_we_a), 32'd1);
        checkOutput("cap_addr_15_7", 32'(rec_addr_a), 32'h007F);
        checkOutput("cap_data_15_7", 32'(rec_data_a), 32'hA5);
        checkOutput("cap_we_16_7", 32'(rec_we_b), 32'd0);
        checkOutput("cap_addr_3_2", 32'(rec_addr_c), 32'h0023);
        checkOutput("cap_data_3_2", 32'(rec_data_c), 32'h2B);

        // Short line 3 breaks lock at the following hsync.
        applyStimulus(4, VT, 3, 0, -1, -1);
        checkOutput("short_line_err", 32'(le_cnt), 32'd1);
        checkOutput("short_frame_err", 32'(fe_cnt), 32'd0);
        checkOutput("short_unlock", 32'(locked), 32'd0);
        checkOutput("unlock_delay", 32'(lock_fall_cyc - le_cyc), 32'd1);
        checkOutput("cap_writes_f4", 32'(wr_cnt[4]), 32'd80);
        applyStimulus(5, VT, -1, 0, -1, -1);
        checkOutput("relock_f5", 32'(locked), 32'd0);
        checkOutput("cap_writes_f5", 32'(wr_cnt[5]), 32'd0);
        applyStimulus(6, VT, -1, 0, -1, -1);
        checkOutput("relock_f6", 32'(locked), 32'd1);

        // A frame one line short is caught at the next vsync.
        applyStimulus(7, VT - 1, -1, 0, -1, -1);
        checkOutput("short_frame_pending", 32'(fe_cnt), 32'd0);
        applyStimulus(8, VT, -1, 0, -1, -1);
        checkOutput("frame_err_count", 32'(fe_cnt), 32'd1);
        checkOutput("frame_err_unlock", 32'(locked), 32'd0);
        checkOutput("cap_writes_f8", 32'(wr_cnt[8]), 32'd128);
        applyStimulus(9, VT, -1, 0, -1, -1);
        checkOutput("cap_writes_f9", 32'(wr_cnt[9]), 32'd0);
        applyStimulus(10, VT, -1, 0, -1, -1);
        checkOutput("relock_f10", 32'(locked), 32'd0);
        applyStimulus(11, VT, -1, 0, -1, -1);
        checkOutput("relock_f11", 32'(locked), 32'd1);

        // Reset mid-line at x=10, then two full frames before relock.
        applyStimulus(12, VT, -1, 0, 2, 12);
        applyStimulus(13, VT, -1, 0, -1, -1);
        checkOutput("post_rst_f13", 32'(locked), 32'd0);
        checkOutput("cap_writes_f13", 32'(wr_cnt[13]), 32'd0);
        applyStimulus(14, VT, -1, 0, -1, -1);
        checkOutput("post_rst_f14", 32'(locked), 32'd1);

        // vsync and hsync leading edges in the same cycle.
        applyStimulus(15, VT, -1, HS_START, -1, -1);
        checkOutput("coinc_y_clear", 32'(px_y), 32'd0);
        applyStimulus(16, VT, -1, HS_START, -1, -1);
        checkOutput("coinc_no_ferr", 32'(fe_cnt), 32'd1);
        checkOutput("coinc_no_lerr", 32'(le_cnt), 32'd1);
        checkOutput("coinc_locked", 32'(locked), 32'd1);
        checkOutput("cap_writes_f16", 32'(wr_cnt[16]), 32'd128);
        checkOutput("fs_count_17", 32'(fs_cnt), 32'd17);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
